// File: rtl/fm_read_scheduler_pkg.sv
// Shared types and default geometry for the feature-map read scheduler.
// Defaults track the network_params.h values (NUM_KERNELS banks, 20x20 maps).
package fm_read_scheduler_pkg;

  localparam int DEF_NUM_BANKS  = 8;
  localparam int DEF_FM_DEPTH   = 400;
  localparam int DEF_ADDR_W     = 9;
  localparam int DEF_SEL_W      = 3;
  localparam int DEF_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/fm_read_scheduler_rd_tag_pipe.sv
// Fixed-depth delay line that follows each issued read through the RAM and mux
// latency, so the flags line up with the data at the mux output.
module rd_tag_pipe
  import fm_read_scheduler_pkg::*;
#(
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [RD_LATENCY];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_out = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/fm_read_scheduler.sv
// Walks every (address, bank) pair of the feature-map and weight banks into the
// fully-connected MAC array: address outer loop, bank inner loop.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for buffer-full with the trigger armed
//   ST_ISSUE | one (addr, bank) read per cycle unless hold is high
//   ST_DRAIN | all reads issued, waiting for the final tag to emerge
//   ST_DONE  | one-cycle product_rdy, then back to idle
module fm_read_scheduler
  import fm_read_scheduler_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int FM_DEPTH   = DEF_FM_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  ram_select,
  output logic              rd_valid,
  output logic              acc_clear,
  output logic              last,
  output logic              product_rdy,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FM_DEPTH - 1);
  localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_BANKS - 1);

  state_t  state;
  logic    armed;
  logic    issue;
  logic    at_last_bank;
  logic    at_last_addr;
  rd_tag_t tag_in;
  rd_tag_t tag_out;

  assign at_last_bank = (ram_select == LAST_SEL);
  assign at_last_addr = (addr == LAST_ADDR);
  assign issue        = (state == ST_ISSUE) && !hold;

  // A held cycle still pushes a tag (valid=0) so latency stays fixed.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.first = issue && (addr == '0) && (ram_select == '0);
    tag_in.last  = issue && at_last_addr && at_last_bank;
  end

  // armed only re-sets after start drops, so a level buffer_full fires once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      armed       <= 1'b1;
      addr        <= '0;
      ram_select  <= '0;
      product_rdy <= 1'b0;
      busy        <= 1'b0;
    end else begin
      product_rdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          addr       <= '0;
          ram_select <= '0;
          if (start && armed) begin
            state <= ST_ISSUE;
            armed <= 1'b0;
            busy  <= 1'b1;
          end else if (!start) begin
            armed <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            if (tag_in.last) begin
              state <= ST_DRAIN;
            end else if (at_last_bank) begin
              ram_select <= '0;
              addr       <= addr + ADDR_W'(1);
            end else begin
              ram_select <= ram_select + SEL_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (tag_out.valid && tag_out.last) begin
            state       <= ST_DONE;
            product_rdy <= 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          addr       <= '0;
          ram_select <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rd_tag_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rd_valid  = tag_out.valid;
  assign acc_clear = tag_out.valid & tag_out.first;
  assign last      = tag_out.valid & tag_out.last;

endmodule

// File: doc/fm_read_scheduler.md
Name: fm_read_scheduler

Overview:
- Sequences readout of the per-kernel feature-map RAM banks and weight ROM banks into the fully-connected (np) matrix-multiply stage, once the feature-map buffer reports full.
- Drives a shared read address and bank select, with address as the outer loop and bank as the inner loop.
- Tracks RAM+mux read latency and flags data validity, first and last to the MAC units.
- Single instance, between the feature-map buffer controller and the np matrix-multiply array.

Parameters:
- NUM_BANKS, 8, number of feature-map/weight banks (equals `NUM_KERNELS).
- FM_DEPTH, 400, words per bank (feature-map pixels per kernel).
- ADDR_W, 9, address width; must satisfy 2**ADDR_W >= FM_DEPTH.
- SEL_W, 3, bank-select width; must satisfy 2**SEL_W >= NUM_BANKS.
- RD_LATENCY, 2, cycles from address/select issue to valid data at the read-port mux output; must be >= 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level from the feature-map buffer controller (buffer_full).
- hold  in  1  back-pressure: suppress new issues while high.
- addr  out  ADDR_W  read address to all FM RAMs and weight ROMs.
- ram_select  out  SEL_W  bank select to both read-port muxes.
- rd_valid  out  1  mux output data valid this cycle.
- acc_clear  out  1  with the first rd_valid of a run; MAC loads instead of accumulating.
- last  out  1  with the final rd_valid of a run.
- product_rdy  out  1  one-cycle pulse: all products accumulated.
- busy  out  1  high from first issue through the product_rdy cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; armed=1; tag pipeline cleared.
- States:
  - IDLE -> ISSUE when start && armed. On that transition addr=0, ram_select=0, and armed clears.
  - ISSUE: each cycle with hold=0 issues (addr, ram_select). Select increments; at NUM_BANKS-1 it wraps to 0 and addr increments. Issuing (FM_DEPTH-1, NUM_BANKS-1) goes to DRAIN.
  - DRAIN: no issues. When the last tag exits the pipeline, go to DONE.
  - DONE: product_rdy=1 for exactly one cycle, then IDLE. In IDLE, addr and ram_select return to 0.
- Re-arm: armed sets only when in IDLE with start=0. A level start held high after DONE does not retrigger.
- start while busy is ignored.
- hold during ISSUE:
  - addr and ram_select are frozen and no issue occurs.
  - A bubble (tag valid=0) enters the pipeline, which always shifts every cycle.
  - hold has no effect in IDLE, DRAIN or DONE.
- Tag pipeline: RD_LATENCY stages of {valid, first, last}, shifting every cycle.
  - Entry is valid=issue, first=(issue of 0,0), last=(issue of final pair).
  - Outputs: rd_valid=tag.valid, acc_clear=tag.valid&tag.first, last=tag.valid&tag.last.
- Timing with N=NUM_BANKS*FM_DEPTH and no hold (cycle 0 = edge where start is sampled):
  - Issues occur in cycles 1..N.
  - rd_valid is high in cycles 1+RD_LATENCY..N+RD_LATENCY.
  - product_rdy is high in cycle N+RD_LATENCY+1.
  - busy is high in cycles 1..N+RD_LATENCY+1.
  - Each hold cycle in ISSUE delays all subsequent events by one.
- Counter widths: addr compares against FM_DEPTH-1 exactly, so non-power-of-2 depths never emit out-of-range addresses.
- Asynchronous reset mid-run aborts immediately. Pipeline tags are cleared, so no rd_valid, last or product_rdy is emitted afterwards. armed=1 after reset.

Decomposition:
- network_params.h holds the defines these parameters default from: FM_DEPTH, FM addr width, bank-select width, and read latency (with `NUM_KERNELS for NUM_BANKS).
- One sub-module, rd_tag_pipe: a parameterised RD_LATENCY-deep delay line for {valid, first, last} with asynchronous clear.
- The FSM and counters stay in fm_read_scheduler.

Test Plan:
- NUM_BANKS=2, FM_DEPTH=3, RD_LATENCY=2, start pulse at cycle 0 -> (addr,sel) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1) in cycles 1-6; rd_valid in cycles 3-8; acc_clear only in cycle 3; last only in cycle 8; product_rdy only in cycle 9; busy in cycles 1-9.
- Same config, hold=1 in cycles 2-3 -> addr/sel stay (0,1) through cycle 4; rd_valid low in cycles 4-5; last in cycle 10; product_rdy in cycle 11.
- start held high continuously -> exactly one run and one product_rdy. Drop start for 1 cycle, raise again -> second identical run.
- start toggled during ISSUE and DRAIN -> no effect on sequence or counts.
- Assert reset in cycle 4 of a run -> all outputs 0 in the same cycle. No rd_valid, last or product_rdy afterwards. A later start gives a clean full run.
- Default config (8 banks, depth 400) -> exactly 3200 rd_valid; max addr seen is 399; product_rdy in cycle 3203.
